// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

    // Arbiter FSM: normal arbitration, or a one-cycle forced pipeline bubble.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } arb_state_e;

    // Handshake port indices, also used as the round-robin pointer encoding.
    localparam logic PORT_MD = 1'b0;
    localparam logic PORT_LD = 1'b1;

    // Default register-file geometry.
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    // One write request {addr, data} at the default geometry.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of writeback sources, handshake ports and register-file write outputs.
// Handshake rule for md/ld: a transfer happens on a rising clk edge where
// valid && ready; ready is combinational, and a source keeps addr/data stable
// while valid is high and ready is low.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0] md_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              pipe_stall;
    logic              RegWrite;
    logic [ADDR_W-1:0] addD;
    logic [DATA_W-1:0] WB_out;
    logic              proto_err;

    // Producers side: drives requests, observes readies and the write port.
    modport master (
        output wb_valid, wb_addr, wb_data,
        output md_valid, md_addr, md_data,
        output ld_valid, ld_addr, ld_data,
        input  md_ready, ld_ready, pipe_stall,
        input  RegWrite, addD, WB_out, proto_err
    );

    // Arbiter side.
    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  md_valid, md_addr, md_data,
        input  ld_valid, ld_addr, ld_data,
        output md_ready, ld_ready, pipe_stall,
        output RegWrite, addD, WB_out, proto_err
    );
endinterface

// File: rtl/rf_write_arbiter_starve_ctr.sv
// Saturating wait counter for one handshake port plus starvation trigger.
module rf_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic ready,
    output logic trig
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt;

    // Count consecutive blocked cycles, saturating; any non-blocked cycle clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (valid && !ready) begin
            if (cnt != CW'(STARVE_LIMIT)) begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Fire when this blocked cycle is the STARVE_LIMIT-th one. The >= keeps a
    // saturated port triggering again after a bubble served the other port.
    assign trig = valid && !ready && (cnt >= CW'(STARVE_LIMIT - 1));

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority,
// mul/div and load ports share the rest round-robin, and a starved port can
// force a one-cycle pipeline bubble. Write outputs are registered.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    rf_write_arbiter_if.slave         bus,
    output arb_state_e                dbg_state
);
    arb_state_e        state_q, state_d;
    logic              rr_q, rr_d;
    logic              stall_port_q, stall_port_d;
    logic              proto_err_q;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic wb_live;
    logic gnt_wb, gnt_md, gnt_ld;
    logic md_rdy, ld_rdy;
    logic md_trig, ld_trig;

    // A write to x0 never needs the port.
    assign wb_live = bus.wb_valid && (bus.wb_addr != '0);

    // Grant selection; all readies held low while in reset.
    always_comb begin
        gnt_wb = 1'b0;
        md_rdy = 1'b0;
        ld_rdy = 1'b0;
        if (rst_n) begin
            if (state_q == ST_STALL) begin
                md_rdy = (stall_port_q == PORT_MD);
                ld_rdy = (stall_port_q == PORT_LD);
            end else if (wb_live) begin
                gnt_wb = 1'b1;
            end else if (bus.md_valid && bus.ld_valid) begin
                md_rdy = (rr_q == PORT_MD);
                ld_rdy = (rr_q == PORT_LD);
            end else begin
                md_rdy = bus.md_valid;
                ld_rdy = bus.ld_valid;
            end
        end
    end

    assign gnt_md = bus.md_valid && md_rdy;
    assign gnt_ld = bus.ld_valid && ld_rdy;

    assign bus.md_ready = md_rdy;
    assign bus.ld_ready = ld_rdy;

    rf_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_md_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (bus.md_valid),
        .ready (md_rdy),
        .trig  (md_trig)
    );

    rf_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_ld_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (bus.ld_valid),
        .ready (ld_rdy),
        .trig  (ld_trig)
    );

    // Next FSM state, bubble owner and round-robin pointer.
    always_comb begin
        state_d      = ST_RUN;
        stall_port_d = stall_port_q;
        rr_d         = rr_q;
        if (state_q == ST_STALL) begin
            rr_d = ~stall_port_q;
        end else begin
            if (gnt_md) begin
                rr_d = PORT_LD;
            end else if (gnt_ld) begin
                rr_d = PORT_MD;
            end
            if (md_trig && ld_trig) begin
                state_d      = ST_STALL;
                stall_port_d = rr_q;
            end else if (md_trig) begin
                state_d      = ST_STALL;
                stall_port_d = PORT_MD;
            end else if (ld_trig) begin
                state_d      = ST_STALL;
                stall_port_d = PORT_LD;
            end
        end
    end

    // Select the write for next cycle; a handshake to x0 completes silently.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (gnt_wb) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.wb_addr;
            wr_data_d = bus.wb_data;
        end else if (gnt_md) begin
            wr_en_d   = (bus.md_addr != '0);
            wr_addr_d = bus.md_addr;
            wr_data_d = bus.md_data;
        end else if (gnt_ld) begin
            wr_en_d   = (bus.ld_addr != '0);
            wr_addr_d = bus.ld_addr;
            wr_data_d = bus.ld_data;
        end
    end

    // State, pointer, sticky protocol error and the write-port register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            rr_q         <= PORT_MD;
            stall_port_q <= PORT_MD;
            proto_err_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            stall_port_q <= stall_port_d;
            proto_err_q  <= proto_err_q || ((state_q == ST_STALL) && wb_live);
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.pipe_stall = (state_q == ST_STALL);
    assign bus.proto_err  = proto_err_q;
    assign bus.RegWrite   = wr_en_q;
    assign bus.addD       = wr_addr_q;
    assign bus.WB_out     = wr_data_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized bench for rf_write_arbiter with a cycle-level model.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic       clk;
    logic       rst_n;
    arb_state_e dbg_state;

    rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rf_write_arbiter #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: consecutive blocked cycles per port (unbounded),
    // whose turn it is, whether the coming cycle is a bubble and for whom.
    int          m_turn;
    bit          m_bubble;
    int          m_bport;
    int          m_blocked [2];
    bit          m_proto;
    bit          m_en;
    bit          m_rdy     [2];
    bit          m_taken   [2];
    bit          m_was_rst;
    logic [AW+DW-1:0] exp_q [$];
    int          served [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic set_wb(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_valid = v; bus.wb_addr = a; bus.wb_data = d;
    endtask

    task automatic set_md(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.md_valid = v; bus.md_addr = a; bus.md_data = d;
    endtask

    task automatic set_ld(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ld_valid = v; bus.ld_addr = a; bus.ld_data = d;
    endtask

    // One clock cycle: check readies against the model, advance the model,
    // cross the edge, then check the registered outputs.
    task automatic step();
        bit               v [2];
        logic [AW-1:0]    a [2];
        logic [DW-1:0]    d [2];
        bit               live;
        bit               cand [2];
        int               old_turn;
        logic [AW+DW-1:0] e;
        #1;
        v[0] = bus.md_valid; a[0] = bus.md_addr; d[0] = bus.md_data;
        v[1] = bus.ld_valid; a[1] = bus.ld_addr; d[1] = bus.ld_data;
        live = bus.wb_valid && (bus.wb_addr != 0);
        m_rdy[0] = 0; m_rdy[1] = 0;
        if (!rst_n) begin
        end else if (m_bubble) begin
            m_rdy[m_bport] = 1;
        end else if (live) begin
        end else if (v[0] && v[1]) begin
            m_rdy[m_turn] = 1;
        end else begin
            m_rdy[0] = v[0]; m_rdy[1] = v[1];
        end
        check("md_ready", bus.md_ready, m_rdy[0]);
        check("ld_ready", bus.ld_ready, m_rdy[1]);
        for (int k = 0; k < 2; k++) m_taken[k] = v[k] && m_rdy[k];
        m_was_rst = !rst_n;
        if (!rst_n) begin
            m_turn = 0; m_bubble = 0; m_bport = 0; m_proto = 0; m_en = 0;
            m_blocked[0] = 0; m_blocked[1] = 0;
            exp_q.delete();
        end else begin
            m_en = 0;
            if (!m_bubble && live) begin
                m_en = 1;
                exp_q.push_back({bus.wb_addr, bus.wb_data});
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (m_taken[k] && a[k] != 0) begin
                        m_en = 1;
                        exp_q.push_back({a[k], d[k]});
                    end
                end
            end
            if (m_bubble && live) m_proto = 1;
            old_turn = m_turn;
            for (int k = 0; k < 2; k++)
                cand[k] = !m_bubble && v[k] && !m_rdy[k] && (m_blocked[k] + 1 >= LIMIT);
            for (int k = 0; k < 2; k++)
                m_blocked[k] = (v[k] && !m_rdy[k]) ? m_blocked[k] + 1 : 0;
            if (m_bubble) m_turn = 1 - m_bport;
            else if (m_taken[0]) m_turn = 1;
            else if (m_taken[1]) m_turn = 0;
            m_bubble = cand[0] || cand[1];
            if (cand[0] && cand[1]) m_bport = old_turn;
            else if (cand[0]) m_bport = 0;
            else if (cand[1]) m_bport = 1;
        end
        @(posedge clk);
        #1;
        check("RegWrite", bus.RegWrite, m_en);
        if (m_en) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("addD", bus.addD, e[AW+DW-1:DW]);
                check("WB_out", bus.WB_out, e[DW-1:0]);
            end
        end
        if (m_was_rst) begin
            check("rst_addD", bus.addD, 0);
            check("rst_WB_out", bus.WB_out, 0);
        end
        check("pipe_stall", bus.pipe_stall, m_bubble);
        check("proto_err", bus.proto_err, m_proto);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Random handshake source: hold while pending, else maybe issue anew.
    task automatic drive_src(input int k);
        bit               nv;
        logic [AW-1:0]    na;
        logic [DW-1:0]    nd;
        bit               cur;
        cur = (k == 0) ? bus.md_valid : bus.ld_valid;
        if (!cur || m_taken[k]) begin
            nv = $urandom_range(0, 1);
            na = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
            nd = $urandom;
            if (k == 0) set_md(nv, na, nd);
            else        set_ld(nv, na, nd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m_taken[0] = 0; m_taken[1] = 0;
        set_wb(0, 0, 0); set_md(0, 0, 0); set_ld(0, 0, 0);
        @(posedge clk); #1;
        do_reset();
        check("reset_RegWrite", bus.RegWrite, 0);
        check("reset_pipe_stall", bus.pipe_stall, 0);

        // Pipeline writeback wins over both handshake ports.
        set_wb(1, 5, 32'hDEADBEEF);
        set_md(1, 3, 32'h0000_0303);
        set_ld(1, 4, 32'h0000_0404);
        #1;
        check("t1_md_ready", bus.md_ready, 0);
        check("t1_ld_ready", bus.ld_ready, 0);
        step();
        check("t1_RegWrite", bus.RegWrite, 1);
        check("t1_addD", bus.addD, 5);
        check("t1_WB_out", bus.WB_out, 32'hDEADBEEF);

        // Both ports held valid: md, ld, md, ld with a write every cycle.
        set_wb(0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            set_md(1, 3, 32'h1000 + c);
            set_ld(1, 4, 32'h2000 + c);
            #1;
            check("t2_md_ready", bus.md_ready, (c % 2) == 0);
            step();
            check("t2_RegWrite", bus.RegWrite, 1);
            check("t2_addD", bus.addD, ((c % 2) == 0) ? 3 : 4);
        end

        // Constant pipeline traffic starves md until the forced bubble.
        do_reset();
        set_ld(0, 0, 0);
        set_md(1, 9, 32'hCAFE_0009);
        for (int c = 0; c < 6; c++) begin
            if (m_bubble) set_wb(0, 0, 0);
            else set_wb(1, AW'($urandom_range(1, 31)), $urandom);
            if (c == 5) set_md(0, 0, 0);
            #1;
            if (c < 5) check("t3_md_ready", bus.md_ready, c == 4);
            step();
            if (c < 5) check("t3_pipe_stall", bus.pipe_stall, c == 3);
            if (c == 4) check("t3_md_addD", bus.addD, 9);
        end

        // Both ports starve together: first bubble serves md, the next ld.
        do_reset();
        set_md(1, 11, 32'hAAAA_0011);
        set_ld(1, 12, 32'hBBBB_0012);
        served.delete();
        for (int c = 0; c < 10; c++) begin
            if (m_bubble) set_wb(0, 0, 0);
            else set_wb(1, AW'($urandom_range(1, 31)), $urandom);
            if (bus.pipe_stall) begin
                #1;
                served.push_back(int'(bus.ld_ready));
            end
            step();
            if (m_taken[0]) set_md(0, 0, 0);
            if (m_taken[1]) set_ld(0, 0, 0);
        end
        check("t4_bubbles", served.size(), 2);
        if (served.size() >= 2) begin
            check("t4_first_served_ld", served[0], 0);
            check("t4_second_served_ld", served[1], 1);
        end

        // Pipeline write to x0 does not block ld; a handshake to x0 is silent.
        set_wb(1, 0, 32'h1234_5678);
        set_md(0, 0, 0);
        set_ld(1, 7, 32'h0777_0777);
        #1;
        check("t5_ld_ready", bus.ld_ready, 1);
        step();
        check("t5_addD", bus.addD, 7);
        set_wb(0, 0, 0);
        set_ld(0, 0, 0);
        set_md(1, 0, 32'h5555_5555);
        #1;
        check("t5_md_ready", bus.md_ready, 1);
        step();
        check("t5_RegWrite_x0", bus.RegWrite, 0);
        set_md(0, 0, 0);

        // Live pipeline write during the bubble sets the sticky error; reset clears all.
        do_reset();
        set_md(1, 13, 32'hD00D_0013);
        for (int c = 0; c < 5; c++) begin
            set_wb(1, (c == 4) ? AW'(2) : AW'(1 + c), 32'hF00 + c);
            step();
        end
        check("t6_proto_err", bus.proto_err, 1);
        set_wb(0, 0, 0);
        set_md(0, 0, 0);
        step();
        step();
        check("t6_proto_sticky", bus.proto_err, 1);
        set_wb(1, 6, 32'h6666_6666);
        set_md(1, 14, 32'h0E0E_0E0E);
        rst_n = 1'b0;
        #1;
        check("t6_rst_md_ready", bus.md_ready, 0);
        step();
        rst_n = 1'b1;
        check("t6_rst_RegWrite", bus.RegWrite, 0);
        check("t6_rst_addD", bus.addD, 0);
        check("t6_rst_WB_out", bus.WB_out, 0);
        check("t6_rst_pipe_stall", bus.pipe_stall, 0);
        check("t6_rst_proto_err", bus.proto_err, 0);
        check("t6_rst_state", dbg_state, ST_RUN);

        // Randomized traffic with occasional resets.
        set_wb(0, 0, 0); set_md(0, 0, 0); set_ld(0, 0, 0);
        m_taken[0] = 0; m_taken[1] = 0;
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            if (m_bubble) set_wb(0, 0, 0);
            else set_wb($urandom_range(0, 9) < 7,
                        ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31)),
                        $urandom);
            drive_src(0);
            drive_src(1);
            step();
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
